// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation mode encodings and a
// compile-time width check that every instantiating module can expand.
`define ADDER_WIDTH_CHECK(W, S) \
    if (((W) % (S)) != 0) begin : g_width_check \
        $error("adder: WIDTH must be divisible by STAGES"); \
    end

package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-bit ripple slice of the pipelined adder; the partial sum and the
// carry out are registered and only update while the pipe is advancing.
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_q,
    output logic             cout_q
);

    logic [CHUNK-1:0] sum_d;
    logic             cout_d;

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        if (en) begin
            {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: rtl/pipelined_generic_adder.sv
// WIDTH-bit add/subtract split into STAGES registered carry-chain slices with a
// valid/ready stream on both sides. Define ADDER_SAT_EN for signed saturation.
module pipelined_generic_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    `ADDER_WIDTH_CHECK(WIDTH, STAGES)

    logic              advance;
    logic              carry_in;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  merged [STAGES];
    logic [CHUNK-1:0]  slice_sum [STAGES];
    logic [STAGES-1:0] slice_carry;
    logic [WIDTH-1:0]  raw_sum;
    logic              a_msb, b_msb;

    assign out_valid = valid_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    always_comb begin
        b_eff    = (sub == MODE_SUB) ? ~bin : bin;
        carry_in = (sub == MODE_ADD) ? cin : 1'b1;
    end

    // Operands ride along with the beat so slice k sees its chunk one stage
    // later; finished low chunks are skewed forward in res so they emerge aligned.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            res_d[k] = res_q[k];
        end
        if (advance) begin
            valid_d[0] = in_valid;
            a_d[0]     = ain;
            b_d[0]     = b_eff;
            res_d[0]   = '0;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                a_d[k]     = a_q[k-1];
                b_d[k]     = b_q[k-1];
                res_d[k]   = merged[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [CHUNK-1:0] op_a, op_b;
        logic             op_c;

        if (k == 0) begin : g_first
            assign op_a = ain[CHUNK-1:0];
            assign op_b = b_eff[CHUNK-1:0];
            assign op_c = carry_in;
        end else begin : g_rest
            assign op_a = a_q[k-1][k*CHUNK +: CHUNK];
            assign op_b = b_q[k-1][k*CHUNK +: CHUNK];
            assign op_c = slice_carry[k-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .en     (advance),
            .a      (op_a),
            .b      (op_b),
            .cin    (op_c),
            .sum_q  (slice_sum[k]),
            .cout_q (slice_carry[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            merged[k] = res_q[k];
            merged[k][k*CHUNK +: CHUNK] = slice_sum[k];
        end
    end

    assign raw_sum = merged[STAGES-1];
    assign a_msb   = a_q[STAGES-1][WIDTH-1];
    assign b_msb   = b_q[STAGES-1][WIDTH-1];
    assign carry   = slice_carry[STAGES-1];
    assign ovf     = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef ADDER_SAT_EN
    // Both operands share the sign of the true result, so a_msb picks the rail.
    always_comb begin
        sum = raw_sum;
        if (ovf) begin
            sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_pipelined_generic_adder.sv
// Self-checking bench for pipelined_generic_adder: directed corner beats plus a
// randomized valid/ready stream scored against an arithmetic reference model.
module tb_pipelined_generic_adder;

   localparam int WIDTH  = 24;
   localparam int STAGES = 3;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic             held_valid = 1'b0;
   logic [WIDTH-1:0] held_sum;
   logic             held_carry;
   logic             held_ovf;

   pipelined_generic_adder #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ain       (ain),
      .bin       (bin),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference: plain signed/unsigned integer arithmetic on the operand values.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c, input logic s);
      exp_t   e;
      longint ua, ub, sa, sb, res, total;
      longint modulus, max_s, min_s;
      modulus = longint'(1) << WIDTH;
      max_s   = (longint'(1) << (WIDTH-1)) - 1;
      min_s   = -(longint'(1) << (WIDTH-1));
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         e.sum   = WIDTH'(ua - ub);
         e.carry = (ua >= ub);
         res     = sa - sb;
      end else begin
         total   = ua + ub + longint'(c);
         e.sum   = WIDTH'(total);
         e.carry = (total >= modulus);
         res     = sa + sb + longint'(c);
      end
      e.ovf = (res > max_s) || (res < min_s);
`ifdef ADDER_SAT_EN
      if (e.ovf) e.sum = (res > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
      return e;
   endfunction

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic c, input logic s);
      in_valid = v;
      ain      = a;
      bin      = b;
      cin      = c;
      sub      = s;
   endtask

   // Scoreboard runs on the falling edge, where inputs and outputs are both settled.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            checkOutput("stall_valid", 64'(out_valid), 64'(1));
            checkOutput("stall_sum", 64'(sum), 64'(held_sum));
            checkOutput("stall_carry", 64'(carry), 64'(held_carry));
            checkOutput("stall_ovf", 64'(ovf), 64'(held_ovf));
         end
         if (out_valid && !out_ready) checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
         if (out_valid && out_ready) begin
            checkOutput("result_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               checkOutput("sb_sum", 64'(sum), 64'(mon_e.sum));
               checkOutput("sb_carry", 64'(carry), 64'(mon_e.carry));
               checkOutput("sb_ovf", 64'(ovf), 64'(mon_e.ovf));
               n_out++;
            end
         end
         held_valid = out_valid && !out_ready;
         held_sum   = sum;
         held_carry = carry;
         held_ovf   = ovf;
         if (in_valid && in_ready) exp_q.push_back(model(ain, bin, cin, sub));
      end
   end

   // Single beat into an empty pipe: checks the exact latency and the result.
   task automatic expectResult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic s, input logic [WIDTH-1:0] exp_sum,
                               input logic exp_carry, input logic exp_ovf);
      out_ready = 1'b1;
      applyStimulus(1'b1, a, b, c, s);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int cyc = 1; cyc < STAGES; cyc++) begin
         checkOutput({tag, "_early"}, 64'(out_valid), 64'(0));
         @(posedge clk); #1;
      end
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'(1));
      checkOutput({tag, "_sum"}, 64'(sum), 64'(exp_sum));
      checkOutput({tag, "_carry"}, 64'(carry), 64'(exp_carry));
      checkOutput({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
   endtask

   task automatic drain(input string tag);
      int budget;
      budget    = 200;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      checkOutput({tag, "_drained"}, 64'(exp_q.size() == 0), 64'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             acc;
      int               sent, cyc, out_start;

      rst       = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b1, 24'd9, 24'd9, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_sum", 64'(sum), 64'(0));
      checkOutput("reset_carry", 64'(carry), 64'(0));
      checkOutput("reset_ovf", 64'(ovf), 64'(0));
      checkOutput("reset_in_ready", 64'(in_ready), 64'(1));

      expectResult("add", 24'd100, 24'd23, 1'b1, 1'b0, 24'd124, 1'b0, 1'b0);
      expectResult("wrap", 24'hFFFFFF, 24'd1, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0);
      expectResult("sub", 24'd5, 24'd7, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0);
`ifdef ADDER_SAT_EN
      expectResult("ovf", 24'h7FFFFF, 24'd1, 1'b0, 1'b0, 24'h7FFFFF, 1'b0, 1'b1);
`else
      expectResult("ovf", 24'h7FFFFF, 24'd1, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
`endif
      drain("directed");

      $display("[TB] backpressure stream");
      out_start = n_out;
      sent      = 0;
      cyc       = 0;
      while (sent < 16 && cyc < 500) begin
         out_ready = (cyc % 3 == 0);
         applyStimulus(1'b1, WIDTH'(sent), WIDTH'(2 * sent), 1'b0, 1'b0);
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      checkOutput("bp_all_sent", 64'(sent), 64'(16));
      drain("bp");
      checkOutput("bp_count", 64'(n_out - out_start), 64'(16));

      $display("[TB] random stream");
      for (int n = 0; n < 400; n++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         case ($urandom_range(0, 7))
            0: ra = 24'hFFFFFF;
            1: ra = 24'h7FFFFF;
            2: rb = 24'h800000;
            3: rb = ra;
            default: ;
         endcase
         applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain("rand");

      $display("[TB] mid-stream reset");
      out_ready = 1'b1;
      applyStimulus(1'b1, 24'd10, 24'd20, 1'b0, 1'b0);
      @(posedge clk); #1;
      applyStimulus(1'b1, 24'd30, 24'd40, 1'b0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput("rst_flush", 64'(out_valid), 64'(0));
         @(posedge clk); #1;
      end
      expectResult("rst_next", 24'd1, 24'd1, 1'b0, 1'b0, 24'd2, 1'b0, 1'b0);
      drain("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
